zx_mem_loader: RTL and testbench
================================

ZX_MEM_LOADER -- requirements
Module: zx_mem_loader

Interface
REQ-001 The module SHALL have parameter VERIFY, default 1, meaning read back and compare every written byte when 1.
REQ-002 The module SHALL have parameter AW, default 16, meaning the memory address width in bits.
REQ-003 Port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port s_valid  input  1  a stream byte is offered.
REQ-006 Port s_data  input  8  the stream byte.
REQ-007 Port s_ready  output  1  the loader accepts s_data this cycle.
REQ-008 Port abort  input  1  synchronous frame cancel.
REQ-009 Port mem_a  output  AW  memory address.
REQ-010 Port mem_din  output  8  memory write data.
REQ-011 Port mem_we  output  1  memory write enable.
REQ-012 Port mem_ce  output  1  memory chip enable.
REQ-013 Port mem_dout  input  8  memory read data, valid one clock after the address is presented (synchronous RAM/ROM port).
REQ-014 Port busy  output  1  a frame is in progress.
REQ-015 Port done  output  1  one-cycle pulse at frame completion.
REQ-016 Port error  output  1  sticky verify-mismatch flag.
REQ-017 Port err_count  output  16  number of mismatches in the current or last frame.

Function
REQ-018 Frame format SHALL be addr_lo, addr_hi, len_lo, len_hi, then len data bytes; the address is truncated to AW bits and len is 16-bit unsigned.
REQ-019 States SHALL be IDLE, A_LO, A_HI, L_LO, L_HI, DATA, WR, RD, CMP, DONE; IDLE and A_LO are equivalent entry points, with IDLE accepting addr_lo.
REQ-020 A byte SHALL transfer only on a cycle with s_valid and s_ready both high.
REQ-021 s_ready SHALL be high only in IDLE, A_HI, L_LO, L_HI and DATA, and SHALL be low in all other states.
REQ-022 Accepting addr_lo in IDLE SHALL clear error and err_count, set busy, and move to A_HI.
REQ-023 Header states SHALL advance one state per accepted byte.
REQ-024 If len is 0 when len_hi is accepted, the loader SHALL go to DONE with no memory cycle.
REQ-025 In DATA, an accepted byte SHALL be latched into mem_din and the loader SHALL move to WR.
REQ-026 In WR, mem_we and mem_ce SHALL be 1 and mem_a SHALL equal the current address.
REQ-027 After WR with VERIFY=1, the loader SHALL go to RD; with VERIFY=0 it SHALL perform the post-byte update of REQ-030.
REQ-028 In RD, mem_ce SHALL be 1, mem_we SHALL be 0 and mem_a SHALL equal the same address.
REQ-029 In CMP, if mem_dout differs from the latched byte, err_count SHALL increment (saturating at 0xFFFF) and error SHALL be set.
REQ-030 The post-byte update SHALL increment the address modulo 2^AW (0xFFFF wraps to 0x0000), decrement remaining, and go to DONE if remaining reaches 0, else to DATA.
REQ-031 Throughput SHALL be 4 cycles per byte with VERIFY=1 and 2 cycles per byte with VERIFY=0, given s_valid is held high.
REQ-032 mem_we SHALL be 1 only in WR, and mem_ce SHALL be 0 in every state other than WR and RD.
REQ-033 DONE SHALL last one cycle with done=1 and busy=0, then return to IDLE.
REQ-034 busy SHALL be 1 from the cycle after addr_lo is accepted until DONE.
REQ-035 When abort is high in any state, the next state SHALL be IDLE with no further memory cycle, and done SHALL NOT pulse.
REQ-036 If abort is high in WR, that cycle's write SHALL still occur.
REQ-037 error and err_count SHALL persist after DONE or abort until the next frame starts.

Reset
REQ-038 Asserting reset SHALL immediately force state IDLE and set s_ready=1, busy=0, done=0, error=0, err_count=0, mem_we=0, mem_ce=0, mem_a=0 and mem_din=0.
REQ-039 A reset asserted mid-frame SHALL discard the frame and SHALL NOT restore memory already written.

Structure
REQ-040 The state encoding and frame header length constant (4) SHALL live in shared package zx_loader_pkg.
REQ-041 No sub-module SHALL be instantiated; memories SHALL be connected externally.

Verification
REQ-042 Frame 00 40 03 00 AA BB CC, VERIFY=1, ideal RAM -> writes 0x4000=AA, 0x4001=BB, 0x4002=CC; done pulses once; error=0; err_count=0; 12 cycles from first data accept to done.
REQ-043 Frame FF FF 02 00 11 22 (AW=16) -> writes 0xFFFF=11 and 0x0000=22, confirming wrap-around.
REQ-044 Frame 00 00 02 00 55 66 to a read-only model (ROM with ce tied low on write) holding 00 -> err_count=2, error=1, done pulses.
REQ-045 Frame with len=0000 -> no mem_ce assertion and done one cycle after len_hi is accepted.
REQ-046 abort after 2 of 5 data bytes -> exactly 2 writes, done never pulses, busy=0, and the next frame is accepted normally.
REQ-047 s_valid toggled every other cycle with VERIFY=0 -> data is written correctly and s_ready is never high outside the states listed in REQ-021.

Source files
------------

// File: rtl/zx_loader_pkg.sv
// zx_loader_pkg: shared types for the ZX memory loader.
// State encoding and frame header constants.
package zx_loader_pkg;

   localparam int HDR_LEN = 4;

   typedef enum logic [3:0] {
      IDLE = 4'd0,
      A_LO = 4'd1,
      A_HI = 4'd2,
      L_LO = 4'd3,
      L_HI = 4'd4,
      DATA = 4'd5,
      WR   = 4'd6,
      RD   = 4'd7,
      CMP  = 4'd8,
      DONE = 4'd9
   } ld_state_t;

endpackage

// File: rtl/zx_mem_loader.sv
// zx_mem_loader: streams an addressed frame into memory,
// optionally reading each byte back and counting mismatches.
module zx_mem_loader
   import zx_loader_pkg::*;
#(
   parameter int VERIFY = 1,
   parameter int AW     = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          s_valid,
   input  logic [7:0]    s_data,
   output logic          s_ready,
   input  logic          abort,
   output logic [AW-1:0] mem_a,
   output logic [7:0]    mem_din,
   output logic          mem_we,
   output logic          mem_ce,
   input  logic [7:0]    mem_dout,
   output logic          busy,
   output logic          done,
   output logic          error,
   output logic [15:0]   err_count
);

   ld_state_t     state_q;
   ld_state_t     state_d;
   logic [AW-1:0] addr_q;
   logic [7:0]    alo_q;
   logic [7:0]    llo_q;
   logic [15:0]   rem_q;
   logic [7:0]    din_q;
   logic          error_q;
   logic [15:0]   errcnt_q;
   logic          take;
   logic          last;

   assign take = s_valid & s_ready;
   assign last = (rem_q == 16'd1);

   // Output decode straight from registered state
   always_comb begin
      s_ready = 1'b0;
      busy    = 1'b0;
      mem_we  = 1'b0;
      mem_ce  = 1'b0;
      done    = 1'b0;
      unique case (1'b1)
         (state_q == IDLE): s_ready = 1'b1;
         (state_q == A_HI),
         (state_q == L_LO),
         (state_q == L_HI),
         (state_q == DATA): begin
            s_ready = 1'b1;
            busy    = 1'b1;
         end
         (state_q == WR): begin
            busy   = 1'b1;
            mem_we = 1'b1;
            mem_ce = 1'b1;
         end
         (state_q == RD): begin
            busy   = 1'b1;
            mem_ce = 1'b1;
         end
         (state_q == CMP): busy = 1'b1;
         (state_q == DONE): done = 1'b1;
         default: ;
      endcase
   end

   assign mem_a     = addr_q;
   assign mem_din   = din_q;
   assign error     = error_q;
   assign err_count = errcnt_q;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; abort overrides everything
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (take) state_d = A_HI;
         A_LO: state_d = IDLE;
         A_HI: if (take) state_d = L_LO;
         L_LO: if (take) state_d = L_HI;
         L_HI: begin
            if (take) begin
               if ({s_data, llo_q} == 16'd0) state_d = DONE;
               else                          state_d = DATA;
            end
         end
         DATA: if (take) state_d = WR;
         WR: begin
            if (VERIFY != 0) state_d = RD;
            else if (last)   state_d = DONE;
            else             state_d = DATA;
         end
         RD:  state_d = CMP;
         CMP: state_d = last ? DONE : DATA;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort) state_d = IDLE;
   end

   // Header capture, data latch, address walk and verify bookkeeping
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q   <= '0;
         alo_q    <= '0;
         llo_q    <= '0;
         rem_q    <= '0;
         din_q    <= '0;
         error_q  <= 1'b0;
         errcnt_q <= '0;
      end else if (!abort) begin
         unique case (state_q)
            IDLE: begin
               if (take) begin
                  alo_q    <= s_data;
                  error_q  <= 1'b0;
                  errcnt_q <= '0;
               end
            end
            A_HI: if (take) addr_q <= AW'({s_data, alo_q});
            L_LO: if (take) llo_q <= s_data;
            L_HI: if (take) rem_q <= {s_data, llo_q};
            DATA: if (take) din_q <= s_data;
            WR: begin
               if (VERIFY == 0) begin
                  addr_q <= addr_q + 1'b1;
                  rem_q  <= rem_q - 1'b1;
               end
            end
            CMP: begin
               if (mem_dout != din_q) begin
                  error_q <= 1'b1;
                  if (errcnt_q != 16'hFFFF)
                     errcnt_q <= errcnt_q + 1'b1;
               end
               addr_q <= addr_q + 1'b1;
               rem_q  <= rem_q - 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_zx_mem_loader.sv
// tb_zx_mem_loader: directed checks of zx_mem_loader with
// verify on (RAM and ROM model) and verify off.
module tb_zx_mem_loader;
   import zx_loader_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;

   logic        v1 = 1'b0, v0 = 1'b0;
   logic [7:0]  d1 = 8'h00, d0 = 8'h00;
   logic        ab1 = 1'b0, ab0 = 1'b0;
   logic        r1, r0;
   logic [15:0] a1, a0;
   logic [7:0]  din1, din0, q1, q0;
   logic        we1, we0, ce1, ce0;
   logic        busy1, busy0, done1, done0;
   logic        err1, err0;
   logic [15:0] ec1, ec0;

   logic        rom_mode = 1'b0;
   logic [7:0]  mem1 [0:65535];
   logic [7:0]  mem0 [0:65535];

   int wr1 = 0, ce1n = 0, dn1 = 0, dcyc1 = 0;
   int wr0 = 0, dn0 = 0, viol = 0;

   always #5 clk = ~clk;

   zx_mem_loader #(.VERIFY(1), .AW(16)) dut1 (
      .clk(clk), .reset(reset),
      .s_valid(v1), .s_data(d1), .s_ready(r1), .abort(ab1),
      .mem_a(a1), .mem_din(din1), .mem_we(we1), .mem_ce(ce1),
      .mem_dout(q1), .busy(busy1), .done(done1),
      .error(err1), .err_count(ec1)
   );

   zx_mem_loader #(.VERIFY(0), .AW(16)) dut0 (
      .clk(clk), .reset(reset),
      .s_valid(v0), .s_data(d0), .s_ready(r0), .abort(ab0),
      .mem_a(a0), .mem_din(din0), .mem_we(we0), .mem_ce(ce0),
      .mem_dout(q0), .busy(busy0), .done(done0),
      .error(err0), .err_count(ec0)
   );

   // Synchronous RAM models; ROM mode ignores writes and reads 00
   always @(posedge clk) begin
      cyc++;
      if (ce1 && we1 && !rom_mode) mem1[a1] <= din1;
      if (ce1) q1 <= rom_mode ? 8'h00 : mem1[a1];
      if (ce0 && we0) mem0[a0] <= din0;
      if (ce0) q0 <= mem0[a0];
   end

   // Event monitors sampled mid-cycle
   always @(negedge clk) begin
      if (ce1 && we1) wr1++;
      if (ce1) ce1n++;
      if (done1) begin dn1++; dcyc1 = cyc; end
      if (ce0 && we0) wr0++;
      if (done0) dn0++;
      if ((r1 && ce1) || (r0 && ce0)) viol++;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input int sel, input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      if (sel == 1) begin v1 = 1'b1; d1 = b; end
      else          begin v0 = 1'b1; d0 = b; end
      while (!(sel == 1 ? r1 : r0) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("ready_timeout", n, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int sel);
      @(negedge clk);
      if (sel == 1) v1 = 1'b0;
      else          v0 = 1'b0;
   endtask

   int t_acc, wbase, dbase, cbase;

   initial begin
      #1;
      chk("rst_flags", {r1, busy1, done1, err1, we1, ce1}, 6'b100000);
      chk("rst_addr", a1, 0);
      chk("rst_din", din1, 0);
      chk("rst_errcnt", ec1, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Basic 3-byte frame with verify
      wbase = wr1;
      send(1, 8'h00); send(1, 8'h40); send(1, 8'h03); send(1, 8'h00);
      send(1, 8'hAA);
      t_acc = cyc - 1;
      send(1, 8'hBB); send(1, 8'hCC);
      idle(1);
      repeat (20) @(negedge clk);
      chk("f1_m4000", mem1[16'h4000], 8'hAA);
      chk("f1_m4001", mem1[16'h4001], 8'hBB);
      chk("f1_m4002", mem1[16'h4002], 8'hCC);
      chk("f1_writes", wr1 - wbase, 3);
      chk("f1_done", dn1, 1);
      chk("f1_error", err1, 0);
      chk("f1_errcnt", ec1, 0);
      chk("f1_latency", dcyc1 - t_acc, 12);
      chk("f1_idle", {r1, busy1}, 2'b10);

      // Address wrap at top of memory
      send(1, 8'hFF); send(1, 8'hFF); send(1, 8'h02); send(1, 8'h00);
      send(1, 8'h11); send(1, 8'h22);
      idle(1);
      repeat (20) @(negedge clk);
      chk("wrap_mffff", mem1[16'hFFFF], 8'h11);
      chk("wrap_m0000", mem1[16'h0000], 8'h22);
      chk("wrap_done", dn1, 2);

      // Read-only target: every byte mismatches
      rom_mode = 1'b1;
      send(1, 8'h00); send(1, 8'h00); send(1, 8'h02); send(1, 8'h00);
      send(1, 8'h55); send(1, 8'h66);
      idle(1);
      repeat (20) @(negedge clk);
      chk("rom_errcnt", ec1, 2);
      chk("rom_error", err1, 1);
      chk("rom_done", dn1, 3);
      rom_mode = 1'b0;

      // Zero length frame
      cbase = ce1n;
      send(1, 8'h34); send(1, 8'h12); send(1, 8'h00); send(1, 8'h00);
      t_acc = cyc - 1;
      idle(1);
      repeat (6) @(negedge clk);
      chk("len0_no_ce", ce1n - cbase, 0);
      chk("len0_done", dn1, 4);
      chk("len0_latency", dcyc1 - t_acc, 1);
      chk("len0_err_clr", {err1, ec1}, 17'h0);

      // Abort after two of five bytes
      wbase = wr1;
      dbase = dn1;
      send(1, 8'h00); send(1, 8'h30); send(1, 8'h05); send(1, 8'h00);
      send(1, 8'h01); send(1, 8'h02);
      @(negedge clk);
      v1 = 1'b0;
      for (int n = 0; n < 20 && !r1; n++) @(negedge clk);
      ab1 = 1'b1;
      @(negedge clk);
      ab1 = 1'b0;
      repeat (6) @(negedge clk);
      chk("abort_writes", wr1 - wbase, 2);
      chk("abort_no_done", dn1 - dbase, 0);
      chk("abort_busy", busy1, 0);
      chk("abort_m3001", mem1[16'h3001], 8'h02);
      send(1, 8'h10); send(1, 8'h00); send(1, 8'h01); send(1, 8'h00);
      send(1, 8'h77);
      idle(1);
      repeat (10) @(negedge clk);
      chk("after_abort_m0010", mem1[16'h0010], 8'h77);
      chk("after_abort_done", dn1 - dbase, 1);

      // Reset in the middle of a frame
      send(1, 8'h00); send(1, 8'h01); send(1, 8'h01); send(1, 8'h00);
      v1 = 1'b0;
      reset = 1'b1;
      #1;
      chk("midrst_flags", {r1, busy1, ce1}, 3'b100);
      chk("midrst_addr", a1, 0);
      @(negedge clk);
      reset = 1'b0;

      // Verify off, s_valid toggling every other cycle
      send(0, 8'h00); idle(0);
      send(0, 8'h20); idle(0);
      send(0, 8'h04); idle(0);
      send(0, 8'h00); idle(0);
      send(0, 8'hDE); idle(0);
      send(0, 8'hAD); idle(0);
      send(0, 8'hBE); idle(0);
      send(0, 8'hEF); idle(0);
      repeat (10) @(negedge clk);
      chk("nv_m2000", mem0[16'h2000], 8'hDE);
      chk("nv_m2001", mem0[16'h2001], 8'hAD);
      chk("nv_m2002", mem0[16'h2002], 8'hBE);
      chk("nv_m2003", mem0[16'h2003], 8'hEF);
      chk("nv_writes", wr0, 4);
      chk("nv_done", dn0, 1);
      chk("ready_in_mem_cycle", viol, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
